// File: rtl/cci_mpf_prim_fifo1_drain_if.sv
// cci_mpf_prim_fifo1_drain_if: upstream FIFO pull port plus downstream valid/ready port
interface cci_mpf_prim_fifo1_drain_if #(
  parameter int N_DATA_BITS = 32
);
  logic [N_DATA_BITS-1:0] in_first;
  logic                   in_notEmpty;
  logic                   in_deq_en;
  logic [N_DATA_BITS-1:0] out_data;
  logic                   out_valid;
  logic                   out_rdy;
  modport master (
    input  in_first, in_notEmpty, out_rdy,
    output in_deq_en, out_data, out_valid
  );
  modport slave (
    output in_first, in_notEmpty, out_rdy,
    input  in_deq_en, out_data, out_valid
  );
endinterface

// File: rtl/cci_mpf_prim_fifo1_drain.sv
// cci_mpf_prim_fifo1_drain: drains a 1-entry FIFO into a 2-entry skid buffer; CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN adds stall_cnt
module cci_mpf_prim_fifo1_drain #(
  parameter int N_DATA_BITS = 32,
  parameter int N_STAT_BITS = 16
) (
  input logic clk,
  input logic reset_n,
`ifdef CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN
  output logic [N_STAT_BITS-1:0] stall_cnt,
`endif
  cci_mpf_prim_fifo1_drain_if.master io
);
  if (N_DATA_BITS < 1 || N_STAT_BITS < 1) begin : g_bad_cfg
    $error("cci_mpf_prim_fifo1_drain: widths must be positive");
  end
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nxt;
  logic [N_DATA_BITS-1:0] head, tail;
  logic deq, acc, load_head, load_tail;
  // Dequeue depends only on registered occupancy, never on out_rdy.
  assign deq = reset_n & io.in_notEmpty & (state != TWO);
  assign acc = io.out_valid & io.out_rdy;
  assign io.in_deq_en = deq;
  assign io.out_valid = state != EMPTY;
  assign io.out_data = head;
  // Next occupancy and which slot captures the upstream head entry.
  always_comb begin
    state_nxt = (state == EMPTY) ? (deq ? ONE : EMPTY) :
                (state == ONE)   ? ((deq & !acc) ? TWO : (!deq & acc) ? EMPTY : ONE) :
                acc ? ONE : TWO;
    load_head = deq & ((state == EMPTY) | acc);
    load_tail = deq & !acc & (state == ONE);
  end
  // Occupancy, head (output) and tail (skid) registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      if (load_head) head <= io.in_first;
      else if ((state == TWO) && acc) head <= tail;
      if (load_tail) tail <= io.in_first;
    end
  end
`ifdef CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN
  // Saturating count of cycles where valid data waits on the consumer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= '0;
    else if (io.out_valid && !io.out_rdy && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
  // Simulation sanity: legal encoding and no dequeue from an empty upstream FIFO.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (state inside {EMPTY, ONE, TWO}) else $fatal(1, "illegal state encoding %0d", state);
      assert (!(io.in_deq_en && !io.in_notEmpty)) else $fatal(1, "in_deq_en asserted with in_notEmpty=0");
    end
  end
endmodule

// File: tb/tb_cci_mpf_prim_fifo1_drain.sv
// tb_cci_mpf_prim_fifo1_drain: queue-model bench for the drain stage
module tb_cci_mpf_prim_fifo1_drain;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] got[$];
  int unsigned stall_m = 0;
  cci_mpf_prim_fifo1_drain_if #(.N_DATA_BITS(32)) bus ();
`ifdef CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN
  logic [3:0] stall_cnt;
`endif
  cci_mpf_prim_fifo1_drain #(.N_DATA_BITS(32), .N_STAT_BITS(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .io(bus.master)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive at negedge, compare against the queue model, then advance the model at posedge.
  task automatic cycle(input logic ne, input logic rdy, input logic [31:0] d, output logic took);
    logic acc;
    @(negedge clk);
    bus.in_notEmpty = ne;
    bus.out_rdy = rdy;
    bus.in_first = d;
    #1;
    took = reset_n && ne && (q.size() < 2);
    acc = reset_n && (q.size() > 0) && rdy;
    check("in_deq_en", 32'(bus.in_deq_en), 32'(took));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("out_data", bus.out_data, q[0]);
    else if (!reset_n) check("out_data_reset", bus.out_data, 32'h0);
`ifdef CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN
    check("stall_cnt", 32'(stall_cnt), stall_m);
`endif
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      stall_m = 0;
    end else begin
      if ((q.size() > 0) && !rdy && (stall_m < 15)) stall_m++;
      if (acc) got.push_back(q.pop_front());
      if (took) q.push_back(d);
    end
  endtask

  initial begin
    logic took;
    logic offering;
    logic [31:0] src;
    int i;
    bus.in_first = '0;
    bus.in_notEmpty = 1'b0;
    bus.out_rdy = 1'b0;
    // Reset held with upstream offering data: nothing dequeued, outputs cleared.
    repeat (3) cycle(1'b1, 1'b1, 32'hDEAD_BEEF, took);
    #2 reset_n = 1'b1;
    // Single entry flows straight through.
    got.delete();
    cycle(1'b1, 1'b1, 32'hA5A5_0001, took);
    cycle(1'b0, 1'b1, 32'h0, took);
    cycle(1'b0, 1'b1, 32'h0, took);
    check("single_count", got.size(), 1);
    check("single_data", got[0], 32'hA5A5_0001);
    // Backpressure: only two entries fit, head holds, then drains in order.
    i = 1;
    repeat (5) begin
      cycle(1'b1, 1'b0, i, took);
      if (took) i++;
    end
    check("bp_deq_count", i, 4 - 1);
    got.delete();
    repeat (6) begin
      cycle(i <= 3, 1'b1, i, took);
      if (took) i++;
    end
    check("bp_emit_count", got.size(), 3);
    for (int k = 0; k < 3; k++) check("bp_order", got[k], k + 1);
    // Streaming: one entry per cycle after the first.
    got.delete();
    for (int k = 0; k < 100; k++) cycle(1'b1, 1'b1, k, took);
    check("stream_count", got.size(), 99);
    for (int k = 0; k < 99; k++) check("stream_order", got[k], k);
    repeat (3) cycle(1'b0, 1'b1, 32'h0, took);
    // Random traffic; upstream keeps its head stable until it is dequeued.
    src = 32'h1000;
    offering = 1'b0;
    repeat (400) begin
      if (!offering) offering = $urandom_range(0, 2) != 0;
      cycle(offering, $urandom_range(0, 3) != 0, src, took);
      if (took) begin
        src = $urandom;
        offering = 1'b0;
      end
    end
    repeat (3) cycle(1'b0, 1'b1, 32'h0, took);
    // Async reset while full: outputs drop at once, fresh data afterwards.
    cycle(1'b1, 1'b0, 32'h1, took);
    cycle(1'b1, 1'b0, 32'h2, took);
    cycle(1'b1, 1'b0, 32'h3, took);
    @(negedge clk);
    bus.in_notEmpty = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_deq", 32'(bus.in_deq_en), 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    #1 reset_n = 1'b1;
    q.delete();
    stall_m = 0;
    got.delete();
    cycle(1'b1, 1'b1, 32'h7, took);
    cycle(1'b0, 1'b1, 32'h0, took);
    check("post_rst_count", got.size(), 1);
    check("post_rst_first", got[0], 32'h7);
`ifdef CCI_MPF_PRIM_FIFO1_DRAIN_STATS_EN
    // Stall counter saturates at 15 for a 4-bit width.
    cycle(1'b1, 1'b0, 32'h9, took);
    repeat (20) cycle(1'b0, 1'b0, 32'h0, took);
    check("stall_sat", 32'(stall_cnt), 32'd15);
    repeat (2) cycle(1'b0, 1'b1, 32'h0, took);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
